pipeout_block_serializer: RTL and testbench

PIPEOUT_BLOCK_SERIALIZER -- requirements
Module: pipeout_block_serializer

---
 rtl/pipeout_block_serializer.sv | 105 ++++++++++
 tb/tb_pipeout_block_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeout_block_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeout_block_serializer
//  Description : Buffers 64-bit DES result blocks in a small circular FIFO and
//                serialises them as little-endian 16-bit words onto an
//                okPipeOut endpoint, one word per ep_read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeout_block_serializer #(
    // FIFO capacity in 64-bit blocks; power of two in the range 2..16
    parameter int DEPTH = 4
) (
    input  logic                        ti_clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        blk_valid,
    input  logic [63:0]                 blk_data,
    output logic                        blk_ready,
    input  logic                        pipe_read,
    output logic [15:0]                 pipe_data,
    output logic [$clog2(DEPTH*4):0]    words_avail,
    output logic                        underflow
);

    localparam int c_PW = $clog2(DEPTH);        // pointer width
    localparam int c_CW = c_PW + 1;             // block count width (0..DEPTH)
    localparam int c_WW = $clog2(DEPTH*4) + 1;  // word count width (0..DEPTH*4)

    logic [63:0]     r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [1:0]      r_idx;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_pop_last;
    logic            w_uf_set;
    logic [63:0]     w_head;
    logic [15:0]     w_word;

    // Handshake decode; ready depends only on registered count (never on a
    // same-cycle pop), and reset/flush suppress every push and pop.
    always_comb begin
        w_full     = (r_count == c_CW'(DEPTH));
        w_empty    = (r_count == '0);
        w_ready    = reset & ~w_full;
        w_push     = blk_valid & w_ready & ~flush;
        w_pop      = pipe_read & ~w_empty & reset & ~flush;
        w_pop_last = w_pop & (r_idx == 2'd3);
        w_uf_set   = pipe_read & w_empty;
    end

    // Block storage; contents survive reset and flush, only pointers clear.
    always_ff @(posedge ti_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= blk_data;
        end
    end

    // Pointer, word index, block count and sticky underflow bookkeeping.
    always_ff @(posedge ti_clk) begin
        if (!reset || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_idx       <= 2'd0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_idx <= r_idx + 2'd1;
                if (w_pop_last) begin
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                end
            end
            case ({w_push, w_pop_last})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Output mux straight off registered state: current word of the head block.
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_word      = w_head[{r_idx, 4'b0000} +: 16];
        blk_ready   = w_ready;
        pipe_data   = (reset && !w_empty) ? w_word : 16'h0000;
        words_avail = reset ? ({r_count, 2'b00} - c_WW'(r_idx)) : '0;
        underflow   = r_underflow & reset;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeout_block_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeout_block_serializer
//  Description : Self-checking bench for pipeout_block_serializer. A word-queue
//                model tracks the expected output stream; directed sequences
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeout_block_serializer;

    localparam int DEPTH = 4;

    logic        ti_clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        blk_valid = 1'b0;
    logic [63:0] blk_data = 64'h0;
    logic        blk_ready;
    logic        pipe_read = 1'b0;
    logic [15:0] pipe_data;
    logic [4:0]  words_avail;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    pipeout_block_serializer #(.DEPTH(DEPTH)) dut (
        .ti_clk      (ti_clk),
        .reset       (reset),
        .flush       (flush),
        .blk_valid   (blk_valid),
        .blk_data    (blk_data),
        .blk_ready   (blk_ready),
        .pipe_read   (pipe_read),
        .pipe_data   (pipe_data),
        .words_avail (words_avail),
        .underflow   (underflow)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is just a queue of unread 16-bit words.
    logic [15:0] mq[$];
    bit          m_uf = 0;
    bit          started = 0;

    function automatic int model_blocks();
        return (mq.size() + 3) / 4;
    endfunction

    always @(posedge ti_clk) begin
        bit do_push;
        started = 1;
        if (!reset || flush) begin
            mq.delete();
            m_uf = 0;
        end else begin
            do_push = blk_valid && (model_blocks() < DEPTH);
            if (pipe_read) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_uf = 1;
            end
            if (do_push)
                for (int k = 0; k < 4; k++) mq.push_back(blk_data[16*k +: 16]);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge ti_clk) begin
        if (started) begin
            check("cmp_ready", {63'h0, blk_ready}, {63'h0, (reset && model_blocks() < DEPTH)});
            check("cmp_data", {48'h0, pipe_data},
                  {48'h0, ((reset && mq.size() > 0) ? mq[0] : 16'h0000)});
            check("cmp_words", {59'h0, words_avail}, reset ? 64'(mq.size()) : 64'h0);
            check("cmp_uf", {63'h0, underflow}, {63'h0, (m_uf && reset)});
        end
    end

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        pipe_read = 1'b1;
        while (words_avail != 0 && n < 100) begin
            tick();
            n++;
        end
        pipe_read = 1'b0;
        check(name, {59'h0, words_avail}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] blocks [10];
    logic [15:0] got[$];

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        tick(); tick();
        check("rst_ready", {63'h0, blk_ready}, 64'h0);
        check("rst_data", {48'h0, pipe_data}, 64'h0);
        check("rst_words", {59'h0, words_avail}, 64'h0);
        check("rst_uf", {63'h0, underflow}, 64'h0);
        reset = 1'b1;
        tick();
        check("post_rst_ready", {63'h0, blk_ready}, 64'h1);

        // ---------------- single block ----------------
        blk_valid = 1'b1;
        blk_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        blk_valid = 1'b0;
        check("single_w0", {48'h0, pipe_data}, 64'hCDEF);
        check("single_wa4", {59'h0, words_avail}, 64'd4);
        pipe_read = 1'b1;
        tick();
        check("single_w1", {48'h0, pipe_data}, 64'h89AB);
        check("single_wa3", {59'h0, words_avail}, 64'd3);
        tick();
        check("single_w2", {48'h0, pipe_data}, 64'h4567);
        check("single_wa2", {59'h0, words_avail}, 64'd2);
        tick();
        check("single_w3", {48'h0, pipe_data}, 64'h0123);
        check("single_wa1", {59'h0, words_avail}, 64'd1);
        tick();
        pipe_read = 1'b0;
        check("single_empty_data", {48'h0, pipe_data}, 64'h0);
        check("single_wa0", {59'h0, words_avail}, 64'd0);

        // ---------------- full ----------------
        blk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            blk_data = 64'h1000_2000_3000_4000 + 64'(i);
            tick();
        end
        check("full_ready0", {63'h0, blk_ready}, 64'h0);
        check("full_wa16", {59'h0, words_avail}, 64'd16);
        blk_data  = 64'h5555_6666_7777_8888;
        pipe_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_held", {63'h0, blk_ready}, 64'h0);
        end
        tick();
        pipe_read = 1'b0;
        check("full_ready_after_blk0", {63'h0, blk_ready}, 64'h1);
        check("full_wa12", {59'h0, words_avail}, 64'd12);
        check("full_blk1_w0", {48'h0, pipe_data}, 64'h4001);
        tick();
        blk_valid = 1'b0;
        check("full_accept5", {59'h0, words_avail}, 64'd16);
        check("full_ready_again0", {63'h0, blk_ready}, 64'h0);
        drain("full_drain");

        // ---------------- wrap: 10 blocks interleaved ----------------
        for (int i = 0; i < 10; i++)
            blocks[i] = {16'hA000 + 16'(4*i+3), 16'hA000 + 16'(4*i+2),
                         16'hA000 + 16'(4*i+1), 16'hA000 + 16'(4*i)};
        begin
            int pushed;
            int cyc;
            pushed = 0;
            cyc = 0;
            got.delete();
            while ((pushed < 10 || words_avail != 0) && cyc < 300) begin
                blk_valid = (pushed < 10) && (cyc % 5 != 4);
                blk_data  = blocks[(pushed < 10) ? pushed : 9];
                pipe_read = (cyc % 3 != 0) || (pushed >= 10);
                #1;
                if (pipe_read && words_avail != 0) got.push_back(pipe_data);
                if (blk_valid && blk_ready) pushed++;
                if (words_avail > 5'd16) check("wrap_wa_max", {59'h0, words_avail}, 64'd16);
                tick();
                cyc++;
            end
            blk_valid = 1'b0;
            pipe_read = 1'b0;
            check("wrap_done", 64'(cyc < 300), 64'h1);
            check("wrap_count", 64'(got.size()), 64'd40);
            for (int n = 0; n < got.size() && n < 40; n++)
                if (got[n] !== 16'hA000 + 16'(n))
                    check("wrap_word", {48'h0, got[n]}, 64'hA000 + 64'(n));
        end

        // ---------------- underflow ----------------
        pipe_read = 1'b1;
        tick();
        pipe_read = 1'b0;
        check("uf_set", {63'h0, underflow}, 64'h1);
        check("uf_data", {48'h0, pipe_data}, 64'h0);
        tick();
        check("uf_held", {63'h0, underflow}, 64'h1);
        check("uf_wa", {59'h0, words_avail}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("uf_flushed", {63'h0, underflow}, 64'h0);

        // ---------------- simultaneous push and pop ----------------
        blk_valid = 1'b1;
        blk_data  = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        blk_valid = 1'b0;
        pipe_read = 1'b1;
        tick(); tick();
        blk_valid = 1'b1;
        blk_data  = 64'h1111_2222_3333_4444;
        tick();
        blk_valid = 1'b0;
        pipe_read = 1'b0;
        check("simul_wa5", {59'h0, words_avail}, 64'd5);
        check("simul_data", {48'h0, pipe_data}, 64'hAAAA);
        pipe_read = 1'b1;
        tick();
        pipe_read = 1'b0;
        check("simul_next_blk", {48'h0, pipe_data}, 64'h4444);
        drain("simul_drain");

        // ---------------- flush overrides push ----------------
        blk_valid = 1'b1;
        blk_data  = 64'hDEAD_BEEF_0000_1234;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        blk_valid = 1'b0;
        check("flush_push", {59'h0, words_avail}, 64'd0);

        // ---------------- reset mid-block ----------------
        blk_valid = 1'b1;
        blk_data  = 64'h0A0A_0B0B_0C0C_0D0D;
        tick();
        blk_data  = 64'h0E0E_0F0F_1010_1111;
        tick();
        blk_valid = 1'b0;
        pipe_read = 1'b1;
        tick(); tick();
        pipe_read = 1'b0;
        check("rmb_wa6", {59'h0, words_avail}, 64'd6);
        check("rmb_data", {48'h0, pipe_data}, 64'h0B0B);
        reset     = 1'b0;
        blk_valid = 1'b1;
        pipe_read = 1'b1;
        tick();
        check("rmb_wa0", {59'h0, words_avail}, 64'd0);
        check("rmb_ready0", {63'h0, blk_ready}, 64'h0);
        blk_valid = 1'b0;
        pipe_read = 1'b0;
        reset     = 1'b1;
        tick();
        check("rmb_ready1", {63'h0, blk_ready}, 64'h1);
        check("rmb_after_wa", {59'h0, words_avail}, 64'd0);
        check("rmb_after_uf", {63'h0, underflow}, 64'h0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
